// File: rtl/sched_pkg.sv
// Shared types and constants for the two-requester job scheduler.
package sched_pkg;
    localparam int INSTR_W_DEF = 5;
    localparam int ADDR_W_DEF  = 8;

    // A result block is 16 words, so its base must sit on a 16-word boundary.
    localparam logic [3:0] BASE_ALIGN_MASK = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SAVE  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic logic base_ok(input logic [3:0] base_lo);
        return (base_lo & BASE_ALIGN_MASK) == 4'h0;
    endfunction
endpackage

// File: rtl/job_scheduler_if.sv
// Job scheduler bus: requester handshakes, responses, array control and save strobe.
interface job_scheduler_if #(
    parameter int INSTR_W = 5,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
);
    logic               req0_valid, req0_ready;
    logic [INSTR_W-1:0] req0_instr;
    logic [ADDR_W-1:0]  req0_base;
    logic               req1_valid, req1_ready;
    logic [INSTR_W-1:0] req1_instr;
    logic [ADDR_W-1:0]  req1_base;
    logic               rsp0_valid, rsp0_err;
    logic               rsp1_valid, rsp1_err;
    logic               arr_start;
    logic [INSTR_W-1:0] arr_instr;
    logic               arr_done;
    logic               save_into_memory;
    logic [ADDR_W-1:0]  save_base_memory;
    logic               busy;
    logic [CNT_W-1:0]   job_count;

    modport slave (
        input  req0_valid, req0_instr, req0_base,
        input  req1_valid, req1_instr, req1_base, arr_done,
        output req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err,
        output arr_start, arr_instr, save_into_memory, save_base_memory, busy, job_count
    );

    modport master (
        output req0_valid, req0_instr, req0_base,
        output req1_valid, req1_instr, req1_base, arr_done,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err,
        input  arr_start, arr_instr, save_into_memory, save_base_memory, busy, job_count
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; ptr_i names the requester that wins a tie.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o[ptr_i] = 1'b1;
            else                gnt_o        = req_i;
        end
    end
endmodule

// File: rtl/job_scheduler.sv
// Job scheduler: arbitrates two requesters onto the array, saves results, responds.
// Optional hang timeout in WAIT is enabled by defining SCHED_TIMEOUT_EN.
module job_scheduler
    import sched_pkg::*;
#(
    parameter int INSTR_W        = INSTR_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            rst,
    job_scheduler_if.slave  bus
);
    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  base_q;
    logic               owner_q, err_q, ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [1:0]         gnt;
    logic               accept, sel, expire;
    logic [INSTR_W-1:0] sel_instr;
    logic [ADDR_W-1:0]  sel_base;

    rr_arbiter_2 u_arb (
        .req_i ({bus.req1_valid, bus.req0_valid}),
        .ptr_i (ptr_q),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (gnt)
    );

    assign accept    = |gnt;
    assign sel       = gnt[1];
    assign sel_instr = sel ? bus.req1_instr : bus.req0_instr;
    assign sel_base  = sel ? bus.req1_base  : bus.req0_base;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q;

    // Counts WAIT cycles from 0; the last permitted WAIT cycle is TIMEOUT_CYCLES-1.
    assign expire = (state_q == ST_WAIT) && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    to_q <= '0;
        else if (state_q == ST_WAIT) to_q <= to_q + 1'b1;
        else                        to_q <= '0;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = base_ok(sel_base[3:0]) ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.arr_done) state_d = ST_SAVE;
                      else if (expire)  state_d = ST_RESP;
            ST_SAVE:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            base_q  <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= sel_instr;
                base_q  <= sel_base;
                owner_q <= sel;
                err_q   <= ~base_ok(sel_base[3:0]);
                ptr_q   <= ~sel;
            end
            // A done in the expiry cycle takes the normal save path.
            if (expire && !bus.arr_done) err_q <= 1'b1;
            if (state_q == ST_RESP && !err_q) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.req0_ready       = gnt[0];
    assign bus.req1_ready       = gnt[1];
    assign bus.rsp0_valid       = (state_q == ST_RESP) && !owner_q;
    assign bus.rsp1_valid       = (state_q == ST_RESP) &&  owner_q;
    assign bus.rsp0_err         = bus.rsp0_valid && err_q;
    assign bus.rsp1_err         = bus.rsp1_valid && err_q;
    assign bus.arr_start        = (state_q == ST_ISSUE);
    assign bus.arr_instr        = (state_q inside {ST_ISSUE, ST_WAIT, ST_SAVE}) ? instr_q : '0;
    assign bus.save_into_memory = (state_q == ST_SAVE);
    assign bus.save_base_memory = (state_q == ST_SAVE) ? base_q : '0;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.job_count        = cnt_q;
endmodule
